// File: rtl/mux7_scan_ctrl_pkg.sv
// rtl/mux7_scan_ctrl_pkg.sv - shared constants and FSM encoding for the mux7 scan sequencer
// Purpose: channel count, select width and scan FSM state type.
// Ports: none (package).
package mux7_scan_ctrl_pkg;

  localparam int NUM_CH = 7;
  localparam int SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/mux7_scan_ctrl_if.sv
// rtl/mux7_scan_ctrl_if.sv - control/sample bundle between scan sequencer and its user
// Purpose: groups the start/done handshake, the mux select/output and the result word.
// Signals:
//   start    scan request (master -> slave)
//   en_mask  channel enable mask, bit i = mux input i (master -> slave)
//   Z        mux output being sampled (master -> slave)
//   Sel      registered mux select (slave -> master)
//   sample   captured channel values (slave -> master)
//   busy     scan in progress (slave -> master)
//   done     one-cycle completion pulse (slave -> master)
//   valid    sample word is stable (slave -> master)
interface mux7_scan_ctrl_if;
  import mux7_scan_ctrl_pkg::*;

  logic              start;
  logic [NUM_CH-1:0] en_mask;
  logic              Z;
  logic [SEL_W-1:0]  Sel;
  logic [NUM_CH-1:0] sample;
  logic              busy;
  logic              done;
  logic              valid;

  modport master (
    output start, en_mask, Z,
    input  Sel, sample, busy, done, valid
  );

  modport slave (
    input  start, en_mask, Z,
    output Sel, sample, busy, done, valid
  );

endinterface

// File: rtl/mux7_scan_ctrl_next_ch.sv
// rtl/mux7_scan_ctrl_next_ch.sv - priority finder for the next enabled mux channel
// Purpose: returns the lowest enabled channel (first=1) or the lowest enabled
//          channel strictly above cur (first=0).
// Ports:
//   mask   enabled channels
//   cur    current channel
//   first  ignore cur and pick the lowest set bit
//   nxt    selected channel (0 when none found)
//   found  a qualifying channel exists
module mux7_next_ch
  import mux7_scan_ctrl_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  cur,
  input  logic              first,
  output logic [SEL_W-1:0]  nxt,
  output logic              found
);

  // Walk from the top down so the last hit is the lowest qualifying channel.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux7_scan_ctrl.sv
// rtl/mux7_scan_ctrl.sv - round-robin select sequencer and sampler for a 7-to-1 mux
// Purpose: on start, steps Sel through the enabled channels in ascending order,
//          holds each for SETTLE_CYC cycles, captures Z in one capture cycle and
//          assembles the results into a 7-bit word.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of mux7_scan_ctrl_if (start/en_mask/Z in; Sel/sample/busy/done/valid out)
module mux7_scan_ctrl
  import mux7_scan_ctrl_pkg::*;
#(
  parameter int SETTLE_CYC = 2,
  parameter int CNT_W      = 4
) (
  input  logic            clk,
  input  logic            rst,
  mux7_scan_ctrl_if.slave bus
);

  // Counter value on the last settle cycle; unused when SETTLE_CYC is 0.
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    (SETTLE_CYC == 0) ? '0 : CNT_W'(SETTLE_CYC - 1);

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] sample_q, sample_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;

  logic [SEL_W-1:0]  first_ch;
  logic              first_found;
  logic [SEL_W-1:0]  next_ch;
  logic              next_found;

  // First channel comes from the live mask at start; later channels come from
  // the latched mask so en_mask changes cannot disturb a running scan.
  mux7_next_ch u_first (
    .mask  (bus.en_mask),
    .cur   ('0),
    .first (1'b1),
    .nxt   (first_ch),
    .found (first_found)
  );

  mux7_next_ch u_next (
    .mask  (mask_q),
    .cur   (sel_q),
    .first (1'b0),
    .nxt   (next_ch),
    .found (next_found)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      sample_q <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      sample_q <= sample_d;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (!first_found)         state_d = ST_DONE;
          else if (SETTLE_CYC == 0) state_d = ST_CAPTURE;
          else                      state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!next_found)          state_d = ST_DONE;
        else if (SETTLE_CYC == 0) state_d = ST_CAPTURE;
        else                      state_d = ST_SETTLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs. done is raised while in DONE and
  // therefore appears on the cycle after, together with valid.
  always_comb begin
    sel_d    = sel_q;
    sample_d = sample_q;
    mask_d   = mask_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mask_d   = bus.en_mask;
          sample_d = '0;
          valid_d  = 1'b0;
          if (first_found) begin
            sel_d  = first_ch;
            cnt_d  = '0;
            busy_d = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      ST_CAPTURE: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (sel_q == SEL_W'(i)) sample_d[i] = bus.Z;
        end
        if (next_found) begin
          sel_d = next_ch;
          cnt_d = '0;
        end else begin
          busy_d = 1'b0;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.Sel    = sel_q;
  assign bus.sample = sample_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_mux7_scan_ctrl.sv
// tb/tb_mux7_scan_ctrl.sv - directed self-checking bench for mux7_scan_ctrl
module tb_mux7_scan_ctrl;
  import mux7_scan_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] zpat_a = 8'h00;
  logic [7:0] zpat_b = 8'h00;

  mux7_scan_ctrl_if ifa ();
  mux7_scan_ctrl_if ifb ();

  // Model of the 7-to-1 mux: Z is bit Sel of a per-test pattern.
  assign ifa.Z = zpat_a[ifa.Sel];
  assign ifb.Z = zpat_b[ifb.Sel];

  mux7_scan_ctrl #(.SETTLE_CYC(2), .CNT_W(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  mux7_scan_ctrl #(.SETTLE_CYC(0), .CNT_W(4)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit use_b, input logic s, input logic [6:0] m);
    if (use_b) begin
      ifb.start   = s;
      ifb.en_mask = m;
    end else begin
      ifa.start   = s;
      ifa.en_mask = m;
    end
  endtask

  // One scan: start pulse, then per-cycle checks of Sel/busy/valid until done.
  // exp_seq holds the visited channels, 3 bits each, first channel in the LSBs.
  task automatic run_scan(input bit use_b, input logic [6:0] mask, input int per,
                          input logic [20:0] exp_seq, input int nch, input int exp_done,
                          input logic [6:0] exp_sample, input int restart_at,
                          input string tag);
    int         c;
    int         done_c;
    int         cap;
    bit         saw7;
    logic [2:0] sel;
    logic       bsy, dn, vld;
    logic [6:0] smp;
    cap = nch * per;
    @(negedge clk);
    drive(use_b, 1'b1, mask);
    @(negedge clk);
    drive(use_b, 1'b0, ~mask);
    c      = 0;
    done_c = -1;
    saw7   = 1'b0;
    while (c < 64) begin
      sel = use_b ? ifb.Sel  : ifa.Sel;
      bsy = use_b ? ifb.busy : ifa.busy;
      dn  = use_b ? ifb.done : ifa.done;
      vld = use_b ? ifb.valid : ifa.valid;
      if (dn) begin
        done_c = c;
        break;
      end
      if (sel == 3'd7) saw7 = 1'b1;
      if (c < cap) chk({tag, "_sel"}, 32'(sel), 32'(exp_seq[3*(c/per) +: 3]));
      chk({tag, "_busy"}, 32'(bsy), 32'(c < cap));
      chk({tag, "_valid_low"}, 32'(vld), 32'd0);
      @(negedge clk);
      c++;
      drive(use_b, (c == restart_at), ~mask);
    end
    drive(use_b, 1'b0, ~mask);
    chk({tag, "_done_cycle"}, 32'(done_c), 32'(exp_done));
    chk({tag, "_no_sel7"}, 32'(saw7), 32'd0);
    smp = use_b ? ifb.sample : ifa.sample;
    vld = use_b ? ifb.valid : ifa.valid;
    chk({tag, "_sample"}, 32'(smp), 32'(exp_sample));
    chk({tag, "_valid"}, 32'(vld), 32'd1);
    @(negedge clk);
    dn  = use_b ? ifb.done : ifa.done;
    vld = use_b ? ifb.valid : ifa.valid;
    bsy = use_b ? ifb.busy : ifa.busy;
    smp = use_b ? ifb.sample : ifa.sample;
    chk({tag, "_done_pulse"}, 32'(dn), 32'd0);
    chk({tag, "_valid_hold"}, 32'(vld), 32'd1);
    chk({tag, "_busy_after"}, 32'(bsy), 32'd0);
    chk({tag, "_sample_hold"}, 32'(smp), 32'(exp_sample));
  endtask

  initial begin
    int c;
    int ndone;
    drive(1'b0, 1'b0, 7'h00);
    drive(1'b1, 1'b0, 7'h00);

    // Reset state.
    #2;
    chk("rst_a_sel", 32'(ifa.Sel), 32'd0);
    chk("rst_a_sample", 32'(ifa.sample), 32'd0);
    chk("rst_a_busy", 32'(ifa.busy), 32'd0);
    chk("rst_a_done", 32'(ifa.done), 32'd0);
    chk("rst_a_valid", 32'(ifa.valid), 32'd0);
    chk("rst_b_sel", 32'(ifb.Sel), 32'd0);
    chk("rst_b_valid", 32'(ifb.valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Full scan, Z = bit Sel of 1010011.
    zpat_a = 8'b0101_0011;
    run_scan(1'b0, 7'h7F, 3, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 7, 22,
             7'b1010011, -1, "full");
    chk("idle_sel_hold", 32'(ifa.Sel), 32'd6);

    // Sparse mask: channels 0 and 6 only, Z=1.
    zpat_a = 8'hFF;
    run_scan(1'b0, 7'b1000001, 3, {15'd0, 3'd6, 3'd0}, 2, 7, 7'b1000001, -1, "sparse");

    // Empty mask: no busy, done one cycle after start.
    run_scan(1'b0, 7'h00, 3, 21'd0, 0, 1, 7'h00, -1, "empty");

    // Second start four cycles into a full scan is ignored.
    zpat_a = 8'b0101_0011;
    run_scan(1'b0, 7'h7F, 3, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 7, 22,
             7'b1010011, 4, "restart");
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ifa.done) ndone++;
      chk("restart_stay_idle", 32'(ifa.busy), 32'd0);
    end
    chk("restart_single_done", 32'(ndone), 32'd0);

    // Reset mid-scan at Sel=3, applied off the clock edge.
    @(negedge clk);
    drive(1'b0, 1'b1, 7'h7F);
    @(negedge clk);
    drive(1'b0, 1'b0, 7'h7F);
    c = 0;
    while (ifa.Sel != 3'd3 && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("midrst_reach_sel3", 32'(c), 32'd9);
    chk("midrst_pre_sample", 32'(ifa.sample), 32'h03);
    chk("midrst_pre_busy", 32'(ifa.busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sel", 32'(ifa.Sel), 32'd0);
    chk("midrst_sample", 32'(ifa.sample), 32'd0);
    chk("midrst_busy", 32'(ifa.busy), 32'd0);
    chk("midrst_done", 32'(ifa.done), 32'd0);
    chk("midrst_valid", 32'(ifa.valid), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ifa.done) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    chk("midrst_idle_busy", 32'(ifa.busy), 32'd0);
    run_scan(1'b0, 7'h7F, 3, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 7, 22,
             7'b1010011, -1, "after_rst");

    // Zero-settle build: one cycle per channel on 1,3,5.
    zpat_b = 8'h7F;
    run_scan(1'b1, 7'b0101010, 1, {12'd0, 3'd5, 3'd3, 3'd1}, 3, 4, 7'b0101010, -1, "nosettle");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
